// File: rtl/instr_decode_issue.sv
// instr_decode_issue
//   Sits behind the fetch FSM. Takes one 64-bit instruction per instr_valid
//   pulse and decodes it. LOAD, COMP and STORE send a one-cycle start and
//   registered operands to the matching unit, then wait for that unit's done.
//   NOP and illegal opcodes retire at once. HALT parks the block until reset.
//   Every output comes straight from a register.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   instr_valid       one-cycle pulse; the word on instr_in is valid the next cycle
//   instr_in[63:0]    instruction word: [63:60] opcode, [59:40] addr,
//                     [39:24] len, [23:16] buf, [15:0] aux
//   op_addr/len/buf/aux   operands held for the issued unit
//   load/comp/store_start one-cycle start to each unit
//   load/comp/store_done  completion from each unit
//   instr_done        level back to fetch; high from retirement until the next accept
//   busy              high in any state except IDLE and HALTED
//   halted            sticky once a HALT retires
//   err_illegal       sticky; an undefined opcode was seen
//   err_timeout       sticky; a WAIT ran out of cycles
//   instr_count       retired-instruction count; wraps silently
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for instr_valid
// CAPTURE | latch instr_in; fetch drives its bus the cycle after the pulse
// ISSUE   | decode the latched word; start a unit or retire at once
// WAIT    | wait for the issued unit's done, or for the timeout
// HALTED  | HALT retired; ignore everything until rst

module instr_decode_issue #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [63:0]      instr_in,
   output logic [19:0]      op_addr,
   output logic [15:0]      op_len,
   output logic [7:0]       op_buf,
   output logic [15:0]      op_aux,
   output logic             load_start,
   input  logic             load_done,
   output logic             comp_start,
   input  logic             comp_done,
   output logic             store_start,
   input  logic             store_done,
   output logic             instr_done,
   output logic             busy,
   output logic             halted,
   output logic             err_illegal,
   output logic             err_timeout,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_HALTED  = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_COMP  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // A timeout value of 0 turns the timeout off. The counter then runs
   // freely and its value is never used.
   localparam bit             TMO_EN   = (TIMEOUT_CYC != 0);
   localparam int             TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t             state_q, state_d;
   logic [63:0]        instr_q, instr_d;
   logic [19:0]        addr_q, addr_d;
   logic [15:0]        len_q, len_d;
   logic [7:0]         buf_q, buf_d;
   logic [15:0]        aux_q, aux_d;
   logic               ld_start_q, ld_start_d;
   logic               cp_start_q, cp_start_d;
   logic               st_start_q, st_start_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               halted_q, halted_d;
   logic               eill_q, eill_d;
   logic               etmo_q, etmo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               unit_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         buf_q      <= '0;
         aux_q      <= '0;
         ld_start_q <= 1'b0;
         cp_start_q <= 1'b0;
         st_start_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         eill_q     <= 1'b0;
         etmo_q     <= 1'b0;
         cnt_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         buf_q      <= buf_d;
         aux_q      <= aux_d;
         ld_start_q <= ld_start_d;
         cp_start_q <= cp_start_d;
         st_start_q <= st_start_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
         eill_q     <= eill_d;
         etmo_q     <= etmo_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      addr_d     = addr_q;
      len_d      = len_q;
      buf_d      = buf_q;
      aux_d      = aux_q;
      // Starts default low, so a start set in ISSUE lasts exactly one cycle.
      ld_start_d = 1'b0;
      cp_start_d = 1'b0;
      st_start_d = 1'b0;
      done_d     = done_q;
      halted_d   = halted_q;
      eill_d     = eill_q;
      etmo_d     = etmo_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      unit_done  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               done_d  = 1'b0;
               state_d = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            instr_d = instr_in;
            state_d = S_ISSUE;
         end

         S_ISSUE: begin
            case (instr_q[63:60])
               OP_LOAD, OP_COMP, OP_STORE: begin
                  ld_start_d = (instr_q[63:60] == OP_LOAD);
                  cp_start_d = (instr_q[63:60] == OP_COMP);
                  st_start_d = (instr_q[63:60] == OP_STORE);
                  addr_d     = instr_q[59:40];
                  len_d      = instr_q[39:24];
                  buf_d      = instr_q[23:16];
                  aux_d      = instr_q[15:0];
                  tmo_d      = '0;
                  state_d    = S_WAIT;
               end
               OP_NOP: begin
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = S_IDLE;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  cnt_d    = cnt_q + CNT_W'(1);
                  state_d  = S_HALTED;
               end
               default: begin
                  eill_d  = 1'b1;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = S_IDLE;
               end
            endcase
         end

         S_WAIT: begin
            // The latched opcode picks the unit. Done from the other units is ignored.
            case (instr_q[63:60])
               OP_LOAD:  unit_done = load_done;
               OP_COMP:  unit_done = comp_done;
               OP_STORE: unit_done = store_done;
               default:  unit_done = 1'b0;
            endcase
            if (unit_done) begin
               done_d  = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               etmo_d  = 1'b1;
               done_d  = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_HALTED: begin
            state_d = S_HALTED;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = !((state_d == S_IDLE) || (state_d == S_HALTED));
   end

   assign op_addr     = addr_q;
   assign op_len      = len_q;
   assign op_buf      = buf_q;
   assign op_aux      = aux_q;
   assign load_start  = ld_start_q;
   assign comp_start  = cp_start_q;
   assign store_start = st_start_q;
   assign instr_done  = done_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign err_illegal = eill_q;
   assign err_timeout = etmo_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_issue.sv
module tb_instr_decode_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [63:0] instr_in;
   logic [19:0] op_addr;
   logic [15:0] op_len;
   logic [7:0]  op_buf;
   logic [15:0] op_aux;
   logic        load_start, comp_start, store_start;
   logic        load_done, comp_done, store_done;
   logic        instr_done, busy, halted, err_illegal, err_timeout;
   logic [15:0] instr_count;

   always #5 clk = ~clk;

   instr_decode_issue #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
      .op_addr(op_addr), .op_len(op_len), .op_buf(op_buf), .op_aux(op_aux),
      .load_start(load_start), .load_done(load_done),
      .comp_start(comp_start), .comp_done(comp_done),
      .store_start(store_start), .store_done(store_done),
      .instr_done(instr_done), .busy(busy), .halted(halted),
      .err_illegal(err_illegal), .err_timeout(err_timeout),
      .instr_count(instr_count)
   );

   // kind: 0 unit start, 1 retire (instr_done rises), 2 halt (halted rises)
   // flags: {instr_done, halted, err_illegal, err_timeout}
   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] cyc;
      logic [2:0]  starts;
      logic [59:0] ops;
      logic [3:0]  flags;
      logic [15:0] cnt;
   } ev_t;

   ev_t expq[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input logic [1:0] k, input int c, input logic [2:0] s,
                              input logic [59:0] o, input logic [3:0] f, input logic [15:0] n);
      ev_t e;
      e.kind = k; e.cyc = c; e.starts = s; e.ops = o; e.flags = f; e.cnt = n;
      return e;
   endfunction

   function automatic logic [127:0] outs();
      return 128'({op_addr, op_len, op_buf, op_aux, load_start, comp_start, store_start,
                   instr_done, busy, halted, err_illegal, err_timeout, instr_count});
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_ev(input ev_t a);
      ev_t e;
      n_cmp++;
      if (expq.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_event: got kind=%0d cyc=%0d starts=%b ops=%h flags=%b cnt=%0d, expected none",
                  a.kind, a.cyc, a.starts, a.ops, a.flags, a.cnt);
      end else begin
         e = expq.pop_front();
         if (a !== e) begin
            n_bad++;
            $display("FAIL event: got kind=%0d cyc=%0d starts=%b ops=%h flags=%b cnt=%0d, expected kind=%0d cyc=%0d starts=%b ops=%h flags=%b cnt=%0d",
                     a.kind, a.cyc, a.starts, a.ops, a.flags, a.cnt,
                     e.kind, e.cyc, e.starts, e.ops, e.flags, e.cnt);
         end
      end
   endtask

   // Monitor: turns DUT output activity into events and checks them against the queue.
   logic [2:0] st_prev = 3'b000;
   logic       done_prev = 1'b0;
   logic       halt_prev = 1'b0;

   always @(negedge clk) begin : mon
      logic [2:0] st;
      st = {load_start, comp_start, store_start};
      if (st != 3'b000) begin
         chk("start_width", 128'(st_prev), 128'(0));
         compare_ev(mk(2'd0, cyc, st, {op_addr, op_len, op_buf, op_aux}, 4'b0, 16'd0));
      end
      if (instr_done === 1'b1 && done_prev !== 1'b1)
         compare_ev(mk(2'd1, cyc, 3'b0, 60'd0,
                       {instr_done, halted, err_illegal, err_timeout}, instr_count));
      if (halted === 1'b1 && halt_prev !== 1'b1)
         compare_ev(mk(2'd2, cyc, 3'b0, 60'd0,
                       {instr_done, halted, err_illegal, err_timeout}, instr_count));
      st_prev   = st;
      done_prev = instr_done;
      halt_prev = halted;
   end

   // Pulse instr_valid for one cycle. The bus carries the inverted word during
   // the pulse and the real word the next cycle, so early capture shows up.
   // p is the cycle number of the edge that samples the pulse; returns at cyc p+1.
   task automatic pulse(input logic [63:0] ins, output int p);
      @(negedge clk);
      instr_valid = 1'b1;
      instr_in    = ~ins;
      p           = cyc + 1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr_in    = ins;
      @(negedge clk);
      instr_in    = 64'hDEAD_BEEF_CAFE_F00D;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   localparam logic [59:0] L_OPS  = 60'h00ABC_0100_05_0007;
   localparam logic [59:0] C_OPS  = 60'h12345_0010_7F_BEEF;
   localparam logic [59:0] L2_OPS = 60'h54321_0040_22_0001;
   localparam logic [59:0] S_OPS  = 60'h0000F_0020_01_0002;

   initial begin
      int p, p2;
      rst = 1'b1; instr_valid = 1'b0; instr_in = '0;
      load_done = 1'b0; comp_done = 1'b0; store_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 128'(0));
      rst = 1'b0;

      // NOP: retires two edges after the pulse, no start
      pulse(64'h0, p);
      chk("busy_during_decode", 128'(busy), 128'(1));
      expq.push_back(mk(2'd1, p + 2, 3'b0, 60'd0, 4'b1000, 16'd1));
      wait_to(p + 4);
      chk("nop_done_level", 128'(instr_done), 128'(1));

      // LOAD: operand fields, done five cycles after start
      pulse({4'h1, L_OPS}, p);
      chk("done_cleared_on_accept", 128'(instr_done), 128'(0));
      expq.push_back(mk(2'd0, p + 2, 3'b100, L_OPS, 4'b0, 16'd0));
      wait_to(p + 6);
      expq.push_back(mk(2'd1, p + 7, 3'b0, 60'd0, 4'b1000, 16'd2));
      load_done = 1'b1;
      @(negedge clk) load_done = 1'b0;
      wait_to(p + 9);

      // COMP: foreign dones and a stray instr_valid during WAIT are ignored
      pulse({4'h2, C_OPS}, p);
      expq.push_back(mk(2'd0, p + 2, 3'b010, C_OPS, 4'b0, 16'd0));
      wait_to(p + 3);
      store_done = 1'b1; load_done = 1'b1;
      @(negedge clk);
      store_done = 1'b0; load_done = 1'b0; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      expq.push_back(mk(2'd1, p + 6, 3'b0, 60'd0, 4'b1000, 16'd3));
      comp_done = 1'b1;
      @(negedge clk) comp_done = 1'b0;
      wait_to(p + 10);

      // Illegal opcode 7: retire with err_illegal, operands untouched
      pulse({4'h7, 60'hFFFFF_FFFF_FF_FFFF}, p);
      expq.push_back(mk(2'd1, p + 2, 3'b0, 60'd0, 4'b1010, 16'd4));
      wait_to(p + 4);
      chk("illegal_ops_hold", 128'({op_addr, op_len, op_buf, op_aux}), 128'(C_OPS));
      chk("illegal_not_busy", 128'(busy), 128'(0));

      // LOAD whose done lands on the last timeout cycle: done wins, no timeout
      pulse({4'h1, L2_OPS}, p);
      expq.push_back(mk(2'd0, p + 2, 3'b100, L2_OPS, 4'b0, 16'd0));
      wait_to(p + 9);
      expq.push_back(mk(2'd1, p + 10, 3'b0, 60'd0, 4'b1010, 16'd5));
      load_done = 1'b1;
      @(negedge clk) load_done = 1'b0;
      wait_to(p + 12);

      // STORE with no done: timeout after 8 WAIT cycles
      pulse({4'h3, S_OPS}, p);
      expq.push_back(mk(2'd0, p + 2, 3'b001, S_OPS, 4'b0, 16'd0));
      wait_to(p + 9);
      chk("no_early_timeout", 128'({err_timeout, instr_done}), 128'(0));
      expq.push_back(mk(2'd1, p + 10, 3'b0, 60'd0, 4'b1011, 16'd6));
      wait_to(p + 13);

      // Reset during WAIT, then a stray comp_done
      pulse({4'h2, C_OPS}, p);
      expq.push_back(mk(2'd0, p + 2, 3'b010, C_OPS, 4'b0, 16'd0));
      wait_to(p + 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; comp_done = 1'b1;
      @(negedge clk) comp_done = 1'b0;
      wait_to(p + 8);
      chk("reset_mid_wait_outputs", outs(), 128'(0));

      // HALT, then a LOAD pulse and its done are ignored
      pulse({4'hF, 60'd0}, p);
      expq.push_back(mk(2'd2, p + 2, 3'b0, 60'd0, 4'b0100, 16'd1));
      wait_to(p + 4);
      pulse({4'h1, L_OPS}, p2);
      load_done = 1'b1;
      @(negedge clk) load_done = 1'b0;
      wait_to(p2 + 6);
      chk("halted_state", 128'({halted, busy, instr_done, load_start, instr_count}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 16'd1}));

      repeat (3) @(negedge clk);
      chk("all_events_seen", 128'(expq.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
